// File: rtl/gray_code_counter_8_bit_pkg.sv
// Shared helpers for the Gray-code counter: binary-to-Gray mapping and the single-bit-change test.
// Functions work at the maximum supported width; callers zero-extend and truncate with casts.
package gray_pkg;

    localparam int GRAY_MAX_WIDTH = 16;

    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic gray_popcount_is_one(input logic [GRAY_MAX_WIDTH-1:0] old_gray,
                                                  input logic [GRAY_MAX_WIDTH-1:0] new_gray);
        return $countones(old_gray ^ new_gray) == 1;
    endfunction

endpackage

// File: rtl/gray_code_counter_8_bit_bin_to_gray_converter.sv
// Combinational binary-to-Gray converter with an output enable.
// When disabled the output is either released (TRISTATE_EN=1, pad use) or forced to zero (on-chip use).
module bin_to_gray_converter
    import gray_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter bit TRISTATE_EN = 1'b0
) (
    input  logic             Enable_In,
    input  logic [WIDTH-1:0] Bin_Data_In,
    output logic [WIDTH-1:0] Gray_Data_Out
);

    logic [WIDTH-1:0] gray_code;

    assign gray_code = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(Bin_Data_In)));

    generate
        if (TRISTATE_EN) begin : g_tristate
            assign Gray_Data_Out = Enable_In ? gray_code : {WIDTH{1'bz}};
        end else begin : g_gated
            assign Gray_Data_Out = Enable_In ? gray_code : '0;
        end
    endgenerate

endmodule

// File: rtl/gray_code_counter_8_bit.sv
// Registered up/down Gray-code counter with load, wrap/saturate modes, and a sticky step checker.
// Counts in binary; the Gray output is re-derived from the next binary value on the same edge.
module gray_code_counter_8_bit
    import gray_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter bit WRAP_EN = 1'b1
) (
    input  logic             Clock_In,
    input  logic             Reset_In,
    input  logic             Enable_In,
    input  logic             Load_In,
    input  logic [WIDTH-1:0] Load_Data_In,
    input  logic             Count_In,
    input  logic             Up_Down_In,
    output logic [WIDTH-1:0] Gray_Data_Out,
    output logic             Gray_Valid_Out,
    output logic             Wrap_Out,
    output logic             Sat_Out,
    output logic             Step_Error_Out
);

    localparam logic [WIDTH-1:0] BIN_MAX = '1;

    logic [WIDTH-1:0] bin_reg;
    logic [WIDTH-1:0] gray_reg;
    logic             valid_reg;
    logic             wrap_reg;
    logic             sat_reg;
    logic             err_reg;

    logic [WIDTH-1:0] bin_step;
    logic [WIDTH-1:0] conv_in;
    logic [WIDTH-1:0] gray_next;
    logic             would_wrap;
    logic             count_ok;
    logic             sat_block;
    logic             step_taken;
    logic             at_limit_next;
    logic             step_is_single;

    always_comb begin
        bin_step      = Up_Down_In ? (bin_reg + WIDTH'(1)) : (bin_reg - WIDTH'(1));
        would_wrap    = Up_Down_In ? (bin_reg == BIN_MAX) : (bin_reg == '0);
        at_limit_next = Up_Down_In ? (bin_step == BIN_MAX) : (bin_step == '0);
        // Counts before the first load are ignored entirely.
        count_ok      = Enable_In && !Load_In && Count_In && valid_reg;
        sat_block     = count_ok && would_wrap && !WRAP_EN;
        step_taken    = count_ok && !sat_block;
        conv_in       = Load_In ? Load_Data_In : bin_step;
    end

    bin_to_gray_converter #(
        .WIDTH       (WIDTH),
        .TRISTATE_EN (1'b0)
    ) u_conv (
        .Enable_In     (1'b1),
        .Bin_Data_In   (conv_in),
        .Gray_Data_Out (gray_next)
    );

    assign step_is_single = gray_popcount_is_one(GRAY_MAX_WIDTH'(gray_reg), GRAY_MAX_WIDTH'(gray_next));

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            bin_reg   <= '0;
            gray_reg  <= '0;
            valid_reg <= 1'b0;
            wrap_reg  <= 1'b0;
            sat_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else if (!Enable_In) begin
            wrap_reg <= 1'b0;
        end else if (Load_In) begin
            bin_reg   <= Load_Data_In;
            gray_reg  <= gray_next;
            valid_reg <= 1'b1;
            wrap_reg  <= 1'b0;
            sat_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else if (step_taken) begin
            bin_reg  <= bin_step;
            gray_reg <= gray_next;
            // would_wrap can only reach here when wrapping is enabled.
            wrap_reg <= would_wrap;
            sat_reg  <= !WRAP_EN && at_limit_next;
            if (!step_is_single) begin
                err_reg <= 1'b1;
            end
        end else if (sat_block) begin
            wrap_reg <= 1'b0;
            sat_reg  <= 1'b1;
        end else begin
            wrap_reg <= 1'b0;
        end
    end

    assign Gray_Data_Out  = gray_reg;
    assign Gray_Valid_Out = valid_reg;
    assign Wrap_Out       = wrap_reg;
    assign Sat_Out        = sat_reg;
    assign Step_Error_Out = err_reg;

endmodule

// File: tb/tb_gray_code_counter_8_bit.sv
// Bench for gray_code_counter_8_bit: a wrapping and a saturating instance share one stimulus stream,
// checked against a behavioural model through an expectation queue plus hand-written vectors.
module tb_gray_code_counter_8_bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       ld;
    logic [7:0] d;
    logic       cnt;
    logic       up;

    logic [7:0] gray, s_gray;
    logic       valid, wrap, sat, err;
    logic       s_valid, s_wrap, s_sat, s_err;

    always #5 clk = ~clk;

    gray_code_counter_8_bit #(.WIDTH(8), .WRAP_EN(1'b1)) dut (
        .Clock_In(clk), .Reset_In(rst), .Enable_In(en), .Load_In(ld), .Load_Data_In(d),
        .Count_In(cnt), .Up_Down_In(up), .Gray_Data_Out(gray), .Gray_Valid_Out(valid),
        .Wrap_Out(wrap), .Sat_Out(sat), .Step_Error_Out(err)
    );

    gray_code_counter_8_bit #(.WIDTH(8), .WRAP_EN(1'b0)) dut_sat (
        .Clock_In(clk), .Reset_In(rst), .Enable_In(en), .Load_In(ld), .Load_Data_In(d),
        .Count_In(cnt), .Up_Down_In(up), .Gray_Data_Out(s_gray), .Gray_Valid_Out(s_valid),
        .Wrap_Out(s_wrap), .Sat_Out(s_sat), .Step_Error_Out(s_err)
    );

    typedef struct {
        logic [7:0] gray;
        logic       valid;
        logic       wrap;
        logic       sat;
        logic [7:0] s_gray;
        logic       s_sat;
    } exp_t;

    typedef struct {
        logic       en;
        logic       ld;
        logic [7:0] d;
        logic       cnt;
        logic       up;
        logic [7:0] eg;
        logic       ev;
        logic       ew;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    logic [7:0] m_bin, s_bin;
    logic       m_valid, m_wrap, s_sat_m;

    function automatic logic [7:0] to_gray(input logic [7:0] b);
        logic [7:0] g;
        g[7] = b[7];
        for (int i = 0; i < 7; i++) g[i] = b[i] ^ b[i+1];
        return g;
    endfunction

    function automatic logic [7:0] from_gray(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_bin = 8'h00; m_valid = 1'b0; m_wrap = 1'b0;
        s_bin = 8'h00; s_sat_m = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic l, input logic [7:0] dd,
                              input logic c, input logic u);
        if (!e) begin
            m_wrap = 1'b0;
        end else if (l) begin
            m_bin = dd; m_valid = 1'b1; m_wrap = 1'b0;
            s_bin = dd; s_sat_m = 1'b0;
        end else begin
            m_wrap = 1'b0;
            if (c && m_valid) begin
                if (u) begin
                    if (m_bin == 8'hFF) m_wrap = 1'b1;
                    m_bin = m_bin + 8'h01;
                    if (s_bin != 8'hFF) s_bin = s_bin + 8'h01;
                    s_sat_m = (s_bin == 8'hFF);
                end else begin
                    if (m_bin == 8'h00) m_wrap = 1'b1;
                    m_bin = m_bin - 8'h01;
                    if (s_bin != 8'h00) s_bin = s_bin - 8'h01;
                    s_sat_m = (s_bin == 8'h00);
                end
            end
        end
    endtask

    // One clock: drive at negedge, push the model's expectation, compare 1 time unit after posedge.
    task automatic cycle(input logic e, input logic l, input logic [7:0] dd,
                         input logic c, input logic u);
        exp_t x;
        @(negedge clk);
        en = e; ld = l; d = dd; cnt = c; up = u;
        model_step(e, l, dd, c, u);
        x.gray = to_gray(m_bin); x.valid = m_valid; x.wrap = m_wrap; x.sat = 1'b0;
        x.s_gray = to_gray(s_bin); x.s_sat = s_sat_m;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        txn++;
        $display("txn %0d en=%b ld=%b d=%h cnt=%b up=%b -> gray=%h valid=%b wrap=%b err=%b | sat: gray=%h sat=%b wrap=%b",
                 txn, e, l, dd, c, u, gray, valid, wrap, err, s_gray, s_sat, s_wrap);
        check("gray",      gray,         x.gray);
        check("valid",     {7'b0, valid}, {7'b0, x.valid});
        check("wrap",      {7'b0, wrap},  {7'b0, x.wrap});
        check("sat_wrapmode", {7'b0, sat}, {7'b0, x.sat});
        check("step_err",  {7'b0, err},   8'h00);
        check("s_gray",    s_gray,        x.s_gray);
        check("s_sat",     {7'b0, s_sat}, {7'b0, x.s_sat});
        check("s_wrap",    {7'b0, s_wrap}, 8'h00);
        check("s_step_err", {7'b0, s_err}, 8'h00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] prev_gray;
        logic [7:0] frozen;

        rst = 1'b1; en = 1'b0; ld = 1'b0; d = 8'h00; cnt = 1'b0; up = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_gray",  gray, 8'h00);
        check("rst_valid", {7'b0, valid}, 8'h00);
        check("rst_wrap",  {7'b0, wrap}, 8'h00);
        check("rst_sat",   {7'b0, s_sat}, 8'h00);
        check("rst_err",   {7'b0, err}, 8'h00);
        rst = 1'b0;

        // Hand-computed vectors: counts before a load, load+count collision, enable hold, wraps.
        for (int i = 0; i < 5; i++) tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 8'h05, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h06, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
        foreach (tbl[i]) begin
            cycle(tbl[i].en, tbl[i].ld, tbl[i].d, tbl[i].cnt, tbl[i].up);
            check("tbl_gray",  gray, tbl[i].eg);
            check("tbl_valid", {7'b0, valid}, {7'b0, tbl[i].ev});
            check("tbl_wrap",  {7'b0, wrap},  {7'b0, tbl[i].ew});
        end

        // Full up-count lap from 0x00: one Gray bit per step, wrap pulse at FF->00.
        cycle(1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
        prev_gray = gray;
        for (int i = 0; i < 256; i++) begin
            cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
            check("lap_one_bit", 8'($countones(gray ^ prev_gray)), 8'h01);
            if (i == 254) check("lap_at_ff", gray, 8'h80);
            prev_gray = gray;
        end
        check("lap_end_gray", gray, 8'h00);
        check("lap_end_wrap", {7'b0, wrap}, 8'h01);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        check("lap_wrap_drop", {7'b0, wrap}, 8'h00);

        // Saturation on the WRAP_EN=0 instance.
        cycle(1'b1, 1'b1, 8'hFE, 1'b0, 1'b1);
        check("sat_load", s_gray, 8'h81);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
            check("sat_hold_gray", s_gray, 8'h80);
            check("sat_level", {7'b0, s_sat}, 8'h01);
            check("sat_no_wrap", {7'b0, s_wrap}, 8'h00);
        end
        cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        check("sat_release_gray", s_gray, 8'h81);
        check("sat_release", {7'b0, s_sat}, 8'h00);

        // Enable freeze mid-count, then asynchronous reset between edges.
        cycle(1'b1, 1'b1, 8'h10, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        frozen = gray;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            check("freeze_gray", gray, frozen);
        end
        cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_gray",  gray, 8'h00);
        check("async_rst_valid", {7'b0, valid}, 8'h00);
        check("async_rst_sgray", s_gray, 8'h00);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Random traffic; decoding the Gray output must reproduce the binary model every cycle.
        for (int i = 0; i < 2000; i++) begin
            logic e, l, c, u;
            e = ($urandom_range(0, 9) != 0);
            l = ($urandom_range(0, 19) == 0) || (i == 0);
            c = ($urandom_range(0, 9) < 7);
            u = $urandom_range(0, 1) == 1;
            cycle(e, l, 8'($urandom_range(0, 255)), c, u);
            if (m_valid) check("chain_bin", from_gray(gray), m_bin);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
